// File: rtl/sifive_reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sifive_reset_sequencer_pkg
//    Shared definitions for the board-level reset sequencer:
//      - seq_state_e : sequencer state encoding. The encoding is also the
//                      value of the seq_state debug output.
//      - clog2_min1  : ceil(log2(value)) with a minimum result of 1. It sizes
//                      index vectors that must stay at least one bit wide.
// -----------------------------------------------------------------------------
package sifive_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,   // all domains in reset, debouncing PLL lock
      ST_RELEASE  = 2'd1,   // one-cycle step that releases domain cur_domain
      ST_WAIT_ACK = 2'd2,   // waiting for domain_ready[cur_domain]
      ST_RUN      = 2'd3    // every domain released and acknowledged
   } seq_state_e;

   function automatic int clog2_min1(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sifive_reset_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sifive_sync_2ff
//    Two-flop synchronizer for a single asynchronous level signal. Both flops
//    are cleared by the asynchronous reset, so the synchronized output starts
//    at 0. The output follows the input after two clock edges.
//
// Ports
//    clock   in   sampling clock
//    areset  in   asynchronous, active-high reset (clears both flops)
//    d       in   asynchronous input level
//    q       out  synchronized level, registered
// -----------------------------------------------------------------------------
module sifive_sync_2ff (
   input  logic clock,
   input  logic areset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sifive_reset_sequencer.sv
// -----------------------------------------------------------------------------
// sifive_reset_sequencer
//    Board-level reset controller. It keeps NUM_DOMAINS reset outputs asserted
//    until the PLL reports a stable lock. Lock is debounced for 2^HOLD_BITS
//    cycles. The domains are then released strictly in index order, and the
//    sequencer waits for each domain's ready acknowledge before it releases
//    the next one. Any of the following re-asserts every domain and restarts
//    the sequence:
//      - lock loss
//      - an acknowledge timeout
//      - a software restart request
//
// Parameters
//    NUM_DOMAINS       number of sequenced reset outputs (>= 1)
//    HOLD_BITS         lock must be stable for 2^HOLD_BITS cycles
//    ACK_TIMEOUT_BITS  a domain may take up to 2^ACK_TIMEOUT_BITS cycles to ack
//
// Ports
//    clock         in   free-running sequencer clock
//    areset        in   asynchronous, active-high reset
//    pll_locked    in   PLL lock, asynchronous; synchronized internally
//    sw_reset_req  in   single-cycle restart pulse, synchronous to clock
//    domain_ready  in   per-domain acknowledge, synchronous to clock
//    reset_out     out  active-high domain resets (thermometer while releasing)
//    all_done      out  1 only while in RUN
//    timeout_err   out  sticky ack-timeout flag, cleared only by areset
//    seq_state     out  current state (HOLD=0, RELEASE=1, WAIT_ACK=2, RUN=3)
//    cur_domain    out  index of the domain being released / awaited
//
// Release handshake: in RELEASE the sequencer drops reset_out[cur_domain].
// It then waits in WAIT_ACK until the domain raises domain_ready[cur_domain].
// That acknowledge is consumed in the first cycle it is seen. Ready bits of
// the other domains are ignored. If no acknowledge arrives within
// 2^ACK_TIMEOUT_BITS cycles, the whole sequence is retried from HOLD.
//
// Per-cycle priority: areset > lock loss > sw_reset_req > ack > timeout.
// Every output is driven directly from a flop.
// -----------------------------------------------------------------------------
module sifive_reset_sequencer
   import sifive_reset_sequencer_pkg::*;
#(
   parameter int NUM_DOMAINS      = 4,
   parameter int HOLD_BITS        = 8,
   parameter int ACK_TIMEOUT_BITS = 12,
   localparam int DW              = clog2_min1(NUM_DOMAINS)
) (
   input  logic                   clock,
   input  logic                   areset,
   input  logic                   pll_locked,
   input  logic                   sw_reset_req,
   input  logic [NUM_DOMAINS-1:0] domain_ready,
   output logic [NUM_DOMAINS-1:0] reset_out,
   output logic                   all_done,
   output logic                   timeout_err,
   output logic [1:0]             seq_state,
   output logic [DW-1:0]          cur_domain
);

   localparam logic [DW-1:0] LAST_DOMAIN = DW'(NUM_DOMAINS - 1);

   // Synchronized PLL lock
   logic lock_s;

   sifive_sync_2ff u_lock_sync (
      .clock  (clock),
      .areset (areset),
      .d      (pll_locked),
      .q      (lock_s)
   );

   // State and datapath registers
   seq_state_e                  state_q,    state_d;
   logic [HOLD_BITS-1:0]        hold_cnt_q, hold_cnt_d;
   logic [ACK_TIMEOUT_BITS-1:0] tmo_cnt_q,  tmo_cnt_d;
   logic [DW-1:0]               cur_q,      cur_d;
   logic [NUM_DOMAINS-1:0]      rst_q,      rst_d;
   logic                        done_q,     done_d;
   logic                        err_q,      err_d;

   // Lock loss ranks above the software request, but both lead to the same
   // restart, so one abort term covers RELEASE, WAIT_ACK and RUN.
   logic abort;
   assign abort = !lock_s || sw_reset_req;

   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         cur_q      <= '0;
         rst_q      <= '1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         cur_q      <= cur_d;
         rst_q      <= rst_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      cur_d      = cur_q;
      rst_d      = rst_q;
      done_d     = done_q;
      err_d      = err_q;

      unique case (state_q)
         ST_HOLD: begin
            rst_d  = '1;
            done_d = 1'b0;
            cur_d  = '0;
            if (!lock_s || sw_reset_req) begin
               // Any unstable lock cycle, or a restart request, starts the
               // debounce over.
               hold_cnt_d = '0;
            end else if (hold_cnt_q == '1) begin
               // This is the 2^HOLD_BITS-th consecutive locked cycle.
               state_d    = ST_RELEASE;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         ST_RELEASE: begin
            if (abort) begin
               state_d    = ST_HOLD;
               rst_d      = '1;
               done_d     = 1'b0;
               hold_cnt_d = '0;
               tmo_cnt_d  = '0;
               cur_d      = '0;
            end else begin
               // Thermometer: domains 0..cur_domain released, the rest held.
               for (int i = 0; i < NUM_DOMAINS; i++) begin
                  rst_d[i] = (i > int'(cur_q));
               end
               tmo_cnt_d = '0;
               state_d   = ST_WAIT_ACK;
            end
         end

         ST_WAIT_ACK: begin
            if (abort) begin
               state_d    = ST_HOLD;
               rst_d      = '1;
               done_d     = 1'b0;
               hold_cnt_d = '0;
               tmo_cnt_d  = '0;
               cur_d      = '0;
            end else if (domain_ready[cur_q]) begin
               // The acknowledge wins over a timeout in the same cycle.
               if (cur_q == LAST_DOMAIN) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end else begin
                  cur_d   = cur_q + 1'b1;
                  state_d = ST_RELEASE;
               end
            end else if (tmo_cnt_q == '1) begin
               // Retry the whole sequence, including the lock debounce.
               err_d      = 1'b1;
               state_d    = ST_HOLD;
               rst_d      = '1;
               done_d     = 1'b0;
               hold_cnt_d = '0;
               tmo_cnt_d  = '0;
               cur_d      = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            if (abort) begin
               state_d    = ST_HOLD;
               rst_d      = '1;
               done_d     = 1'b0;
               hold_cnt_d = '0;
               tmo_cnt_d  = '0;
               cur_d      = '0;
            end else begin
               rst_d  = '0;
               done_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_HOLD;
            rst_d   = '1;
            done_d  = 1'b0;
         end
      endcase
   end

   assign reset_out   = rst_q;
   assign all_done    = done_q;
   assign timeout_err = err_q;
   assign seq_state   = state_q;
   assign cur_domain  = cur_q;

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sifive_reset_sequencer
//    Directed bench for sifive_reset_sequencer with NUM_DOMAINS=3, HOLD_BITS=4
//    and ACK_TIMEOUT_BITS=4. Inputs change 1 time unit after a rising edge.
//    Outputs are checked at the same point. Edge counts in the comments are
//    measured from the areset release or from the stimulus change just made.
// -----------------------------------------------------------------------------
module tb_sifive_reset_sequencer;

   localparam int N  = 3;
   localparam int HB = 4;
   localparam int AT = 4;

   logic         clock;
   logic         areset;
   logic         pll_locked;
   logic         sw_reset_req;
   logic [N-1:0] domain_ready;
   logic [N-1:0] reset_out;
   logic         all_done;
   logic         timeout_err;
   logic [1:0]   seq_state;
   logic [1:0]   cur_domain;

   int n_checks;
   int n_fail;

   sifive_reset_sequencer #(
      .NUM_DOMAINS      (N),
      .HOLD_BITS        (HB),
      .ACK_TIMEOUT_BITS (AT)
   ) dut (
      .clock        (clock),
      .areset       (areset),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .domain_ready (domain_ready),
      .reset_out    (reset_out),
      .all_done     (all_done),
      .timeout_err  (timeout_err),
      .seq_state    (seq_state),
      .cur_domain   (cur_domain)
   );

   // Clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance n rising edges, then settle 1 unit past the last edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      areset       = 1'b1;
      pll_locked   = 1'b1;
      sw_reset_req = 1'b0;
      domain_ready = 3'b111;

      // 1. Reset state, then the full sequence with every ready tied high
      tick(3);
      check("t1_rst_reset_out", 32'(reset_out), 32'h7);
      check("t1_rst_state", 32'(seq_state), 32'd0);
      check("t1_rst_all_done", 32'(all_done), 32'd0);
      check("t1_rst_timeout_err", 32'(timeout_err), 32'd0);
      check("t1_rst_cur_domain", 32'(cur_domain), 32'd0);
      areset = 1'b0;
      tick(17);                                          // edge 17: count 15
      check("t1_still_hold", 32'(seq_state), 32'd0);
      check("t1_hold_resets", 32'(reset_out), 32'h7);
      tick(1);                                           // edge 18
      check("t1_release", 32'(seq_state), 32'd1);
      tick(1);                                           // edge 19
      check("t1_d0_low", 32'(reset_out), 32'h6);
      check("t1_wait_state", 32'(seq_state), 32'd2);
      tick(2);                                           // edge 21
      check("t1_d1_low", 32'(reset_out), 32'h4);
      check("t1_cur1", 32'(cur_domain), 32'd1);
      tick(2);                                           // edge 23
      check("t1_d2_low", 32'(reset_out), 32'h0);
      check("t1_cur2", 32'(cur_domain), 32'd2);
      tick(1);                                           // edge 24
      check("t1_run", 32'(seq_state), 32'd3);
      check("t1_all_done", 32'(all_done), 32'd1);

      // 2. A one-cycle lock glitch at hold count 10 restarts the debounce
      areset = 1'b1;
      tick(1);
      areset       = 1'b0;
      domain_ready = 3'b001;
      tick(12);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(5);                                           // edge 18
      check("t2_no_early_release", 32'(seq_state), 32'd0);
      tick(12);                                          // edge 30
      check("t2_still_hold", 32'(seq_state), 32'd0);
      tick(1);                                           // edge 31
      check("t2_release", 32'(seq_state), 32'd1);

      // 3. Domain 1 never acknowledges: timeout leads to a full retry
      tick(1);                                           // edge 32
      check("t3_d0_low", 32'(reset_out), 32'h6);
      tick(2);                                           // edge 34
      check("t3_wait_d1_resets", 32'(reset_out), 32'h4);
      check("t3_wait_d1_cur", 32'(cur_domain), 32'd1);
      tick(15);                                          // edge 49: count 15
      check("t3_pre_tmo_state", 32'(seq_state), 32'd2);
      check("t3_pre_tmo_err", 32'(timeout_err), 32'd0);
      tick(1);                                           // edge 50
      check("t3_tmo_state", 32'(seq_state), 32'd0);
      check("t3_tmo_err", 32'(timeout_err), 32'd1);
      check("t3_tmo_resets", 32'(reset_out), 32'h7);
      check("t3_tmo_cur", 32'(cur_domain), 32'd0);
      domain_ready = 3'b111;
      tick(16);
      check("t3_retry_release", 32'(seq_state), 32'd1);
      tick(6);
      check("t3_retry_run", 32'(seq_state), 32'd3);
      check("t3_retry_done", 32'(all_done), 32'd1);
      check("t3_err_sticky", 32'(timeout_err), 32'd1);
      check("t3_run_resets", 32'(reset_out), 32'h0);

      // 4. Lock loss in RUN: two synchronizer edges plus one edge to abort
      pll_locked = 1'b0;
      tick(2);
      check("t4_sync_run", 32'(seq_state), 32'd3);
      check("t4_sync_done", 32'(all_done), 32'd1);
      tick(1);
      check("t4_abort_resets", 32'(reset_out), 32'h7);
      check("t4_abort_done", 32'(all_done), 32'd0);
      check("t4_abort_state", 32'(seq_state), 32'd0);
      pll_locked = 1'b1;
      tick(17);
      check("t4_relock_hold", 32'(seq_state), 32'd0);
      tick(1);
      check("t4_relock_release", 32'(seq_state), 32'd1);
      tick(1);
      check("t4_relock_d0", 32'(reset_out), 32'h6);
      tick(5);
      check("t4_relock_run", 32'(seq_state), 32'd3);

      // 5. Software request while waiting on domain 1 beats its ack
      domain_ready = 3'b001;
      sw_reset_req = 1'b1;
      tick(1);
      sw_reset_req = 1'b0;
      check("t5_sw_run_abort", 32'(seq_state), 32'd0);
      check("t5_sw_run_resets", 32'(reset_out), 32'h7);
      tick(16);
      check("t5_release", 32'(seq_state), 32'd1);
      tick(3);
      check("t5_wait_d1", 32'(cur_domain), 32'd1);
      check("t5_wait_d1_resets", 32'(reset_out), 32'h4);
      domain_ready = 3'b011;
      sw_reset_req = 1'b1;
      tick(1);
      sw_reset_req = 1'b0;
      check("t5_abort_state", 32'(seq_state), 32'd0);
      check("t5_abort_resets", 32'(reset_out), 32'h7);
      check("t5_abort_cur", 32'(cur_domain), 32'd0);

      // 6. Asynchronous reset clears the sticky error at once; then ack and
      //    timeout arrive in the same cycle on domain 2
      areset = 1'b1;
      #1;
      check("t6_async_err", 32'(timeout_err), 32'd0);
      check("t6_async_state", 32'(seq_state), 32'd0);
      tick(1);
      areset = 1'b0;
      tick(23);                                          // edge 23
      check("t6_wait_d2_state", 32'(seq_state), 32'd2);
      check("t6_wait_d2_cur", 32'(cur_domain), 32'd2);
      check("t6_wait_d2_resets", 32'(reset_out), 32'h0);
      tick(15);                                          // edge 38: count 15
      check("t6_pre_state", 32'(seq_state), 32'd2);
      domain_ready = 3'b111;
      tick(1);
      check("t6_ack_wins_state", 32'(seq_state), 32'd3);
      check("t6_ack_wins_done", 32'(all_done), 32'd1);
      check("t6_ack_wins_err", 32'(timeout_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
